store_commit_buffer: RTL and testbench

In-order buffer of issued-but-unretired stores, sitting between the load/store execution unit and the ROB commit stage. It captures each store's effective address and rs2 data when the store issues. It marks entries committed as the ROB retires their tags. It drains committed stores in program order as `retire_store` transactions to the memory side, where the write cache and RAM consume them. On a branch flush it discards speculative (uncommitted) stores and keeps committed ones.

---
 rtl/store_commit_buffer_pkg.sv | 25 ++
 rtl/store_commit_buffer_scb_ptr.sv | 29 ++
 rtl/store_commit_buffer.sv | 121 ++++++++++++
 tb/tb_store_commit_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/store_commit_buffer_pkg.sv
// rtl/store_commit_buffer_pkg.sv - shared types and defaults for the store commit buffer
//
// retire_store_t : store presented to the memory side {store_ready, mem_address, retire_rs2_data}
// scb_entry      : one buffered store {tag, address, data}; the tag field is sized to the
//                  widest supported ROB tag so the buffer can be built for any TAG_W up to it
// SCB_DEPTH      : default number of buffer entries
package store_commit_buffer_pkg;

    localparam int SCB_DEPTH     = 8;
    localparam int SCB_TAG_W     = 6;
    localparam int SCB_MAX_TAG_W = 16;

    typedef struct packed {
        logic        store_ready;
        logic [31:0] mem_address;
        logic [31:0] retire_rs2_data;
    } retire_store_t;

    typedef struct packed {
        logic [SCB_MAX_TAG_W-1:0] tag;
        logic [31:0]              address;
        logic [31:0]              data;
    } scb_entry;

endpackage

// File: rtl/store_commit_buffer_scb_ptr.sv
// rtl/store_commit_buffer_scb_ptr.sv - wrap-bit pointer register with increment and load
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset (pointer -> 0)
//   inc           : advance pointer by one (modulo 2**W, top bit is the wrap bit)
//   load, load_val: overwrite pointer; load takes priority over inc
//   ptr           : current pointer value
module scb_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/store_commit_buffer.sv
// rtl/store_commit_buffer.sv - in-order buffer of issued stores, drained after ROB commit
//
// Circular FIFO with head (oldest), cmt (first uncommitted) and tail (next free) pointers.
// Committed entries are [head, cmt), pending entries are [cmt, tail).
// Ports:
//   clk, rst                              : clock, synchronous active-high reset
//   flush                                 : discard pending entries (tail <= cmt after commit)
//   wr_valid, wr_tag, wr_address, wr_data : store issue
//   full                                  : no free entry
//   commit_valid, commit_tag              : ROB retire of the store at cmt
//   retire_store, mem_ready               : oldest committed store to memory, accepted on mem_ready
//   empty, count                          : occupancy from registered state
//   commit_err, wr_err                    : registered one-cycle error pulses
// Optional build macro STORE_FWD_EN adds ld_address / fwd_hit / fwd_data load forwarding.
module store_commit_buffer
    import store_commit_buffer_pkg::*;
#(
    parameter int DEPTH = SCB_DEPTH,
    parameter int TAG_W = SCB_TAG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_valid,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic [31:0]              wr_address,
    input  logic [31:0]              wr_data,
    output logic                     full,
    input  logic                     commit_valid,
    input  logic [TAG_W-1:0]         commit_tag,
    output retire_store_t            retire_store,
    input  logic                     mem_ready,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     commit_err,
    output logic                     wr_err
`ifdef STORE_FWD_EN
    ,
    input  logic [31:0]              ld_address,
    output logic                     fwd_hit,
    output logic [31:0]              fwd_data
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head, cmt, tail, cmt_next;
    scb_entry         mem_q [DEPTH];

    logic store_ready_w, pending, commit_ok, wr_ok, drain;

    assign count         = tail - head;
    assign full          = (count == PTR_W'(DEPTH));
    assign empty         = (count == '0);
    assign pending       = (cmt != tail);
    assign store_ready_w = (head != cmt);

    assign commit_ok = commit_valid && pending &&
                       (mem_q[cmt[IDX_W-1:0]].tag == SCB_MAX_TAG_W'(commit_tag));
    // A flush cycle ignores the write entirely, so it neither stores nor errors.
    assign wr_ok     = wr_valid && !full && !flush;
    assign drain     = store_ready_w && mem_ready;
    // Flush truncates to the post-commit cmt so a store committed this cycle survives.
    assign cmt_next  = cmt + {{(PTR_W-1){1'b0}}, commit_ok};

    scb_ptr #(.W(PTR_W)) u_head (
        .clk(clk), .rst(rst), .inc(drain), .load(1'b0), .load_val('0), .ptr(head)
    );
    scb_ptr #(.W(PTR_W)) u_cmt (
        .clk(clk), .rst(rst), .inc(commit_ok), .load(1'b0), .load_val('0), .ptr(cmt)
    );
    scb_ptr #(.W(PTR_W)) u_tail (
        .clk(clk), .rst(rst), .inc(wr_ok), .load(flush), .load_val(cmt_next), .ptr(tail)
    );

    // Entry storage needs no reset: only slots inside [head, tail) are ever observed.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[tail[IDX_W-1:0]] <= '{tag:     SCB_MAX_TAG_W'(wr_tag),
                                        address: wr_address,
                                        data:    wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err     <= 1'b0;
            commit_err <= 1'b0;
        end else begin
            wr_err     <= wr_valid && full && !flush;
            commit_err <= commit_valid && !commit_ok;
        end
    end

    // Fields are zeroed when nothing is ready so outputs are 0 after reset.
    always_comb begin
        retire_store                 = '0;
        retire_store.store_ready     = store_ready_w;
        if (store_ready_w) begin
            retire_store.mem_address     = mem_q[head[IDX_W-1:0]].address;
            retire_store.retire_rs2_data = mem_q[head[IDX_W-1:0]].data;
        end
    end

`ifdef STORE_FWD_EN
    // Walk from oldest to youngest; later matches override, leaving the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PTR_W'(i) < count) &&
                (mem_q[IDX_W'(head[IDX_W-1:0] + IDX_W'(i))].address == ld_address)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_q[IDX_W'(head[IDX_W-1:0] + IDX_W'(i))].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// tb/tb_store_commit_buffer.sv - randomized and directed bench for store_commit_buffer
module tb_store_commit_buffer;
    import store_commit_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int TAG_W = 6;

    logic              clk = 1'b0;
    logic              rst, flush, wr_valid, commit_valid, mem_ready;
    logic [TAG_W-1:0]  wr_tag, commit_tag;
    logic [31:0]       wr_address, wr_data;
    logic              full, empty, commit_err, wr_err;
    logic [3:0]        count;
    retire_store_t     rs;
`ifdef STORE_FWD_EN
    logic [31:0]       ld_address;
    logic              fwd_hit;
    logic [31:0]       fwd_data;
`endif

    always #5 clk = ~clk;

    store_commit_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_tag(wr_tag), .wr_address(wr_address), .wr_data(wr_data),
        .full(full), .commit_valid(commit_valid), .commit_tag(commit_tag),
        .retire_store(rs), .mem_ready(mem_ready), .empty(empty), .count(count),
        .commit_err(commit_err), .wr_err(wr_err)
`ifdef STORE_FWD_EN
        , .ld_address(ld_address), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    // Reference model: program-ordered queue of stores plus number of committed ones at the front.
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [31:0]      addr;
        logic [31:0]      data;
    } ref_store_t;

    ref_store_t q[$];
    int         ncm;
    logic       exp_wr_err, exp_cm_err;
    int         n_cmp = 0;
    int         n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("count", 64'(count), 64'(q.size()));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("store_ready", 64'(rs.store_ready), 64'(ncm > 0));
        chk("mem_address", 64'(rs.mem_address), (ncm > 0) ? 64'(q[0].addr) : 64'd0);
        chk("rs2_data", 64'(rs.retire_rs2_data), (ncm > 0) ? 64'(q[0].data) : 64'd0);
        chk("wr_err", 64'(wr_err), 64'(exp_wr_err));
        chk("commit_err", 64'(commit_err), 64'(exp_cm_err));
`ifdef STORE_FWD_EN
        begin
            logic        hit;
            logic [31:0] d;
            hit = 1'b0;
            d   = '0;
            foreach (q[i]) if (q[i].addr == ld_address) begin hit = 1'b1; d = q[i].data; end
            chk("fwd_hit", 64'(fwd_hit), 64'(hit));
            chk("fwd_data", 64'(fwd_data), 64'(d));
        end
`endif
    endtask

    // Drive one cycle of inputs, advance the model, then sample on the falling edge.
    task automatic cyc(input logic wv, input logic [TAG_W-1:0] wt, input logic [31:0] wa,
                       input logic [31:0] wd, input logic cv, input logic [TAG_W-1:0] ct,
                       input logic mr, input logic fl);
        int  size0;
        bit  full0, legal, drn;
        wr_valid = wv; wr_tag = wt; wr_address = wa; wr_data = wd;
        commit_valid = cv; commit_tag = ct; mem_ready = mr; flush = fl;
        size0 = q.size();
        full0 = (size0 == DEPTH);
        legal = cv && (ncm < size0) && (q[ncm].tag == ct);
        drn   = (ncm > 0) && mr;
        exp_cm_err = cv && !legal;
        exp_wr_err = wv && full0 && !fl;
        if (legal) ncm++;
        if (fl) begin
            while (q.size() > ncm) void'(q.pop_back());
        end else if (wv && !full0) begin
            q.push_back('{tag: wt, addr: wa, data: wd});
        end
        if (drn) begin
            void'(q.pop_front());
            ncm--;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic mr);
        cyc(1'b0, '0, '0, '0, 1'b0, '0, mr, 1'b0);
    endtask

    task automatic do_reset(input logic mr);
        rst = 1'b1;
        mem_ready = mr;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        ncm = 0;
        exp_wr_err = 1'b0;
        exp_cm_err = 1'b0;
        check_outputs();
    endtask

    logic [31:0] held_addr;

    initial begin
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; commit_valid = 1'b0; mem_ready = 1'b0;
        wr_tag = '0; commit_tag = '0; wr_address = '0; wr_data = '0;
`ifdef STORE_FWD_EN
        ld_address = '0;
`endif
        ncm = 0; exp_wr_err = 1'b0; exp_cm_err = 1'b0;
        repeat (2) @(posedge clk);
        do_reset(1'b0);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_full", 64'(full), 64'd0);

        // Single store: write, commit, drain.
        cyc(1'b1, 6'd3, 32'h1001_0004, 32'hAA, 1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b1, 6'd3, 1'b1, 1'b0);
        chk("t1_ready", 64'(rs.store_ready), 64'd1);
        chk("t1_addr", 64'(rs.mem_address), 64'h1001_0004);
        chk("t1_data", 64'(rs.retire_rs2_data), 64'hAA);
        idle(1'b1);
        chk("t1_empty", 64'(empty), 64'd1);
        chk("t1_ready_low", 64'(rs.store_ready), 64'd0);

        // Fill without commits, overflow write, then flush everything away.
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 6'(10 + i), 32'h200 + 32'(i * 4), 32'(i), 1'b0, '0, 1'b0, 1'b0);
        chk("t2_full", 64'(full), 64'd1);
        chk("t2_count", 64'(count), 64'd8);
        cyc(1'b1, 6'd20, 32'h300, 32'h99, 1'b0, '0, 1'b0, 1'b0);
        chk("t2_wr_err", 64'(wr_err), 64'd1);
        chk("t2_count_hold", 64'(count), 64'd8);
        cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        chk("t2_flushed", 64'(empty), 64'd1);

        // Flush in the same cycle as the commit of tag 2.
        cyc(1'b1, 6'd1, 32'h400, 32'h11, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 6'd2, 32'h404, 32'h22, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 6'd3, 32'h408, 32'h33, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b1, 6'd1, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b1, 6'd2, 1'b0, 1'b1);
        chk("t3_count", 64'(count), 64'd2);
        idle(1'b1);
        chk("t3_second", 64'(rs.mem_address), 64'h404);
        idle(1'b1);
        chk("t3_empty", 64'(empty), 64'd1);

        // Wrong-tag commit, then correct one, then a stalled drain.
        cyc(1'b1, 6'd4, 32'h500, 32'h44, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b1, 6'd5, 1'b0, 1'b0);
        chk("t4_commit_err", 64'(commit_err), 64'd1);
        chk("t4_no_ready", 64'(rs.store_ready), 64'd0);
        cyc(1'b0, '0, '0, '0, 1'b1, 6'd4, 1'b0, 1'b0);
        chk("t4_err_clear", 64'(commit_err), 64'd0);
        held_addr = rs.mem_address;
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk("t5_stable", 64'(rs.mem_address), 64'(held_addr));
        end
        idle(1'b1);
        chk("t5_single", 64'(count), 64'd0);

`ifdef STORE_FWD_EN
        ld_address = 32'h100;
        cyc(1'b1, 6'd7, 32'h100, 32'd1, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 6'd8, 32'h100, 32'd2, 1'b0, '0, 1'b0, 1'b0);
        chk("fwd_dir_hit", 64'(fwd_hit), 64'd1);
        chk("fwd_dir_data", 64'(fwd_data), 64'd2);
        cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
`endif

        // Randomized traffic with occasional reset mid-drain.
        for (int n = 0; n < 3000; n++) begin
            logic             wv, cv, mr, fl;
            logic [TAG_W-1:0] ct;
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1'b1);
            end else begin
                fl = ($urandom_range(0, 19) == 0);
                wv = (q.size() < DEPTH) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                cv = ($urandom_range(0, 2) != 0);
                mr = ($urandom_range(0, 2) != 0);
                if (ncm < q.size() && $urandom_range(0, 4) != 0) ct = q[ncm].tag;
                else ct = TAG_W'($urandom);
`ifdef STORE_FWD_EN
                ld_address = 32'h100 + 32'($urandom_range(0, 7) * 4);
`endif
                cyc(wv, TAG_W'($urandom), 32'h100 + 32'($urandom_range(0, 7) * 4), $urandom,
                    cv, ct, mr, fl);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
